// File: rtl/psk_tx_pkg.sv
// psk_tx_pkg: shared constants for the PSK transmit framer.
// Holds the frame state encoding, the Barker-13 word, the payload
// scrambler LFSR seed/taps and the MODE_CTRL bit that selects BPSK.
package psk_tx_pkg;

    // Frame states, kept as plain sized constants for legacy tools
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_BARKER   = 3'd2;
    localparam logic [2:0] ST_PAYLOAD  = 3'd3;
    localparam logic [2:0] ST_TAIL     = 3'd4;

    // Barker-13 word, transmitted MSB first (1 -> +1, 0 -> -1)
    localparam logic [12:0] BARKER13 = 13'b1111100110101;

    // Payload scrambler x^7 + x^6 + 1, restarted at every payload entry
    localparam logic [6:0] LFSR_SEED = 7'h7F;
    localparam logic [6:0] LFSR_TAPS = 7'b1100000;

    // MODE_CTRL bit that selects BPSK (1) or QPSK (0) payload
    localparam int MODE_BPSK_BIT = 0;

    // One LFSR step: the feedback bit is shifted in at bit 0 and is also
    // the bit used to whiten the current payload bit
    function automatic logic [6:0] lfsr_step(input logic [6:0] state);
        return {state[5:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/psk_byte_serializer.sv
// psk_byte_serializer: one-byte input hold register plus payload shifter.
// Presents the current payload symbol bits (I/Q) and flags the last symbol
// of the byte; the bit index steps by 1 (BPSK) or 2 (QPSK) and wraps at 8.
module psk_byte_serializer (
    input  logic       clk_32M768,
    input  logic       rst_n_32M768,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       s_tlast,
    input  logic       load,
    input  logic       advance,
    input  logic       bpsk,
    output logic       hold_valid,
    output logic       pay_i,
    output logic       pay_q,
    output logic       byte_end,
    output logic       byte_last
);

    logic [7:0] hold_byte;
    logic       hold_last;
    logic [7:0] shift_byte;
    logic [2:0] bit_idx;

    assign s_tready = !hold_valid;

    // Hold register: emptied when its byte moves into the shifter, else filled on handshake
    always_ff @(posedge clk_32M768) begin
        if (!rst_n_32M768) begin
            hold_valid <= 1'b0;
            hold_byte  <= 8'h00;
            hold_last  <= 1'b0;
        end else if (load) begin
            hold_valid <= 1'b0;
        end else if (s_tvalid && s_tready) begin
            hold_valid <= 1'b1;
            hold_byte  <= s_tdata;
            hold_last  <= s_tlast;
        end
    end

    // Shifter: reload from the hold register or step the bit index by the symbol width
    always_ff @(posedge clk_32M768) begin
        if (!rst_n_32M768) begin
            shift_byte <= 8'h00;
            byte_last  <= 1'b0;
            bit_idx    <= 3'd0;
        end else if (load) begin
            shift_byte <= hold_byte;
            byte_last  <= hold_last;
            bit_idx    <= 3'd0;
        end else if (advance) begin
            bit_idx <= bit_idx + (bpsk ? 3'd1 : 3'd2);
        end
    end

    // Current symbol bits, MSB first, and end-of-byte detection
    always_comb begin
        pay_i    = shift_byte[3'd7 - bit_idx];
        pay_q    = bpsk ? pay_i : shift_byte[3'd6 - bit_idx];
        byte_end = bpsk ? (bit_idx == 3'd7) : (bit_idx == 3'd6);
    end

endmodule

// File: rtl/psk_packetizer.sv
// psk_packetizer: transmit framer producing preamble, Barker-13, payload
// (BPSK or QPSK) and tail symbols at the ce_1M symbol rate.
// Optional macro PSK_TX_SCRAMBLE_EN: whiten payload bits with a 7-bit LFSR.
module psk_packetizer
    import psk_tx_pkg::*;
#(
    parameter int          PREAMBLE_LEN = 64,
    parameter int          TAIL_LEN     = 8,
    parameter logic [12:0] BARKER       = BARKER13
) (
    input  logic       clk_32M768,
    input  logic       rst_n_32M768,
    input  logic       ce_1M,
    input  logic [3:0] MODE_CTRL,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       s_tlast,
    output logic       sym_I,
    output logic       sym_Q,
    output logic       sym_vld,
    output logic       is_bpsk,
    output logic       frame_start,
    output logic       tx_busy,
    output logic       underrun
);

    localparam int MAX_PT  = (PREAMBLE_LEN > TAIL_LEN) ? PREAMBLE_LEN : TAIL_LEN;
    localparam int MAX_LEN = (MAX_PT > 13) ? MAX_PT : 13;
    localparam int CNT_W   = $clog2(MAX_LEN) + 1;

    localparam logic [CNT_W-1:0] PRE_LAST    = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST   = CNT_W'(TAIL_LEN - 1);
    localparam logic [CNT_W-1:0] BARKER_LAST = CNT_W'(12);

    logic [2:0]       state;
    logic [CNT_W-1:0] count;
    logic             hold_valid;
    logic             pay_i;
    logic             pay_q;
    logic             byte_end;
    logic             byte_last;
    logic             ser_load;
    logic             ser_advance;
    logic             barker_done;
    logic [3:0]       barker_idx;
    logic             barker_bit;
    logic             out_i;
    logic             out_q;
    logic             unused_mode_bits;

    assign unused_mode_bits = ^MODE_CTRL[3:1];

    // Shifter control: load after the last Barker chip or on a back-to-back byte
    always_comb begin
        barker_done = (state == ST_BARKER) && (count == BARKER_LAST);
        barker_idx  = 4'd12 - count[3:0];
        barker_bit  = BARKER[barker_idx];
        ser_advance = ce_1M && (state == ST_PAYLOAD);
        ser_load    = ce_1M && (barker_done ||
                      ((state == ST_PAYLOAD) && byte_end && !byte_last && hold_valid));
    end

    psk_byte_serializer u_serializer (
        .clk_32M768   (clk_32M768),
        .rst_n_32M768 (rst_n_32M768),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tlast      (s_tlast),
        .load         (ser_load),
        .advance      (ser_advance),
        .bpsk         (is_bpsk),
        .hold_valid   (hold_valid),
        .pay_i        (pay_i),
        .pay_q        (pay_q),
        .byte_end     (byte_end),
        .byte_last    (byte_last)
    );

`ifdef PSK_TX_SCRAMBLE_EN
    logic [6:0] lfsr;
    logic [6:0] lfsr_1;
    logic [6:0] lfsr_2;

    // Scrambler bits: I uses the first step, Q (QPSK only) the second
    always_comb begin
        lfsr_1 = lfsr_step(lfsr);
        lfsr_2 = lfsr_step(lfsr_1);
        out_i  = pay_i ^ lfsr_1[0];
        out_q  = pay_q ^ (is_bpsk ? lfsr_1[0] : lfsr_2[0]);
    end

    // LFSR: reseeded on payload entry, one step per transmitted payload bit
    always_ff @(posedge clk_32M768) begin
        if (!rst_n_32M768) begin
            lfsr <= LFSR_SEED;
        end else if (ce_1M) begin
            if (barker_done) begin
                lfsr <= LFSR_SEED;
            end else if (state == ST_PAYLOAD) begin
                lfsr <= is_bpsk ? lfsr_1 : lfsr_2;
            end
        end
    end
`else
    assign out_i = pay_i;
    assign out_q = pay_q;
`endif

    // Frame FSM: symbol outputs reflect the state seen at each ce_1M edge
    always_ff @(posedge clk_32M768) begin
        if (!rst_n_32M768) begin
            state       <= ST_IDLE;
            count       <= '0;
            sym_I       <= 1'b0;
            sym_Q       <= 1'b0;
            sym_vld     <= 1'b0;
            is_bpsk     <= 1'b0;
            frame_start <= 1'b0;
            tx_busy     <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (ce_1M) begin
                case (state)
                    ST_IDLE: begin
                        sym_I   <= 1'b0;
                        sym_Q   <= 1'b0;
                        sym_vld <= 1'b0;
                        tx_busy <= 1'b0;
                        if (hold_valid) begin
                            is_bpsk  <= MODE_CTRL[MODE_BPSK_BIT];
                            underrun <= 1'b0;
                            count    <= '0;
                            state    <= ST_PREAMBLE;
                        end
                    end
                    ST_PREAMBLE: begin
                        sym_I       <= ~count[0];
                        sym_Q       <= ~count[0];
                        sym_vld     <= 1'b1;
                        tx_busy     <= 1'b1;
                        frame_start <= (count == '0);
                        if (count == PRE_LAST) begin
                            count <= '0;
                            state <= ST_BARKER;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                    ST_BARKER: begin
                        sym_I   <= barker_bit;
                        sym_Q   <= barker_bit;
                        sym_vld <= 1'b1;
                        tx_busy <= 1'b1;
                        if (barker_done) begin
                            count <= '0;
                            state <= ST_PAYLOAD;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                    ST_PAYLOAD: begin
                        sym_I   <= out_i;
                        sym_Q   <= out_q;
                        sym_vld <= 1'b1;
                        tx_busy <= 1'b1;
                        if (byte_end) begin
                            if (byte_last) begin
                                count <= '0;
                                state <= ST_TAIL;
                            end else if (!hold_valid) begin
                                underrun <= 1'b1;
                                count    <= '0;
                                state    <= ST_TAIL;
                            end
                        end
                    end
                    ST_TAIL: begin
                        sym_I   <= 1'b1;
                        sym_Q   <= 1'b1;
                        sym_vld <= 1'b1;
                        tx_busy <= 1'b1;
                        if (count == TAIL_LAST) begin
                            count <= '0;
                            state <= ST_IDLE;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                    default: begin
                        count <= '0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
